// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops one word per frame from an upstream FIFO and
// serialises it as start / WIDTH data bits (LSB first) / optional even parity / stop.
module fifo_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             tx,
    output logic             busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_START, S_DATA, S_PARITY, S_STOP
    } state_e;

    state_e             state_q, state_d;
    logic               tx_q, tx_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic               parity_q, parity_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   shift_nxt;
    logic               bit_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            tx_q     <= 1'b1;
            shift_q  <= '0;
            parity_q <= 1'b0;
            cnt_q    <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            tx_q     <= tx_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
        end
    end

    assign shift_nxt = shift_q >> 1;
    assign bit_end   = (cnt_q == CNT_LAST);

    always_comb begin
        state_d  = state_q;
        tx_d     = tx_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        case (state_q)
            S_IDLE: begin
                tx_d  = 1'b1;
                cnt_d = '0;
                idx_d = '0;
                if (fifo_rd_en) state_d = S_FETCH;
            end
            // FIFO read data is valid here, one cycle after the pop
            S_FETCH: begin
                shift_d  = fifo_dout;
                parity_d = ^fifo_dout;
                tx_d     = 1'b0;
                cnt_d    = '0;
                state_d  = S_START;
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        if (PARITY_EN != 0) begin
                            tx_d    = parity_q;
                            state_d = S_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = S_STOP;
                        end
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        shift_d = shift_nxt;
                        tx_d    = shift_nxt[0];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // rst_n gates the pop so nothing is consumed while the block is held in reset
    always_comb begin
        fifo_rd_en = rst_n && (state_q == S_IDLE) && enable && !fifo_empty;
        busy       = (state_q != S_IDLE);
    end

    assign tx = tx_q;

endmodule
